// File: rtl/multi_port_replace.sv
// Cache-way victim selector (tree-PLRU / round-robin / LFSR) with multi-port hit updates.
// Victim registered one cycle after miss_en; accepts a request every cycle, no backpressure.
module multi_port_replace #(
  parameter int DEPTH     = 256,
  parameter int WAY_NUM   = 4,
  parameter int HIT_PORTS = 2,
  parameter int MODE      = 0,
  localparam int WAY_WIDTH  = $clog2(WAY_NUM),
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic [HIT_PORTS-1:0]                 hit_en,
  input  logic [HIT_PORTS-1:0][WAY_WIDTH-1:0]  hit_way,
  input  logic [HIT_PORTS-1:0][ADDR_WIDTH-1:0] hit_index,
  input  logic                                 miss_en,
  input  logic [ADDR_WIDTH-1:0]                miss_index,
  input  logic [WAY_NUM-1:0]                   miss_valid_ways,
  output logic [WAY_WIDTH-1:0]                 miss_way,
  output logic                                 miss_ready
);

  logic                 inv_any;
  logic [WAY_WIDTH-1:0] inv_way;
  logic [WAY_WIDTH-1:0] pol_way;
  logic [WAY_WIDTH-1:0] victim_d;
  logic [WAY_WIDTH-1:0] miss_way_q;
  logic                 miss_ready_q;

  always_comb begin
    inv_any = ~&miss_valid_ways;
    inv_way = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (!miss_valid_ways[i]) inv_way = WAY_WIDTH'(i);
    end
    victim_d = inv_any ? inv_way : pol_way;
  end

  if (MODE == 0) begin : g_plru
    logic [WAY_NUM-2:0] tree_q [DEPTH];
    logic [WAY_NUM-2:0] tree_d [DEPTH];

    function automatic logic [WAY_WIDTH-1:0] plru_victim(input logic [WAY_NUM-2:0] t);
      int node;
      logic [WAY_WIDTH-1:0] w;
      node = 0;
      w    = '0;
      for (int l = 0; l < WAY_WIDTH; l++) begin
        w[WAY_WIDTH-1-l] = t[node];
        node = 2 * node + 1 + int'(t[node]);
      end
      return w;
    endfunction

    // Each node on the way's path is pointed at the opposite subtree.
    function automatic logic [WAY_NUM-2:0] plru_touch(input logic [WAY_NUM-2:0] t,
                                                      input logic [WAY_WIDTH-1:0] w);
      int node;
      logic b;
      logic [WAY_NUM-2:0] r;
      node = 0;
      r    = t;
      for (int l = 0; l < WAY_WIDTH; l++) begin
        b       = w[WAY_WIDTH-1-l];
        r[node] = ~b;
        node    = 2 * node + 1 + int'(b);
      end
      return r;
    endfunction

    assign pol_way = plru_victim(tree_q[miss_index]);

    always_comb begin
      for (int s = 0; s < DEPTH; s++) begin
        tree_d[s] = tree_q[s];
        for (int p = 0; p < HIT_PORTS; p++) begin
          if (hit_en[p] && hit_index[p] == ADDR_WIDTH'(s))
            tree_d[s] = plru_touch(tree_d[s], hit_way[p]);
        end
        if (miss_en && miss_index == ADDR_WIDTH'(s))
          tree_d[s] = plru_touch(tree_d[s], victim_d);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < DEPTH; s++) tree_q[s] <= '0;
      end else if (clear) begin
        for (int s = 0; s < DEPTH; s++) tree_q[s] <= '0;
      end else begin
        for (int s = 0; s < DEPTH; s++) tree_q[s] <= tree_d[s];
      end
    end
  end else if (MODE == 1) begin : g_rr
    logic [WAY_WIDTH-1:0] cnt_q [DEPTH];
    logic                 unused_hit;

    assign unused_hit = ^{hit_en, hit_way, hit_index};
    assign pol_way    = cnt_q[miss_index];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < DEPTH; s++) cnt_q[s] <= '0;
      end else if (clear) begin
        for (int s = 0; s < DEPTH; s++) cnt_q[s] <= '0;
      end else if (miss_en) begin
        cnt_q[miss_index] <= cnt_q[miss_index] + WAY_WIDTH'(1);
      end
    end
  end else begin : g_lfsr
    logic [15:0] lfsr_q;
    logic        lfsr_fb;
    logic        unused_hit;

    assign unused_hit = ^{hit_en, hit_way, hit_index};
    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign pol_way    = lfsr_q[WAY_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lfsr_q <= 16'h0001;
      end else if (clear) begin
        lfsr_q <= 16'h0001;
      end else if (miss_en) begin
        lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      end
    end
  end

  // Victim register ignores clear so a same-cycle miss still gets its pre-clear answer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_way_q   <= '0;
      miss_ready_q <= 1'b0;
    end else begin
      miss_ready_q <= miss_en;
      if (miss_en) miss_way_q <= victim_d;
    end
  end

  assign miss_way   = miss_way_q;
  assign miss_ready = miss_ready_q;

endmodule

// File: tb/tb_multi_port_replace.sv
// Directed bench: one instance per policy, shared stimulus, LFSR reference model.
module tb_multi_port_replace;
  localparam int DEPTH = 256;
  localparam int WN    = 4;
  localparam int HP    = 2;
  localparam int WW    = 2;
  localparam int AW    = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clear;
  logic [HP-1:0]          hit_en;
  logic [HP-1:0][WW-1:0]  hit_way;
  logic [HP-1:0][AW-1:0]  hit_index;
  logic                   miss_en;
  logic [AW-1:0]          miss_index;
  logic [WN-1:0]          miss_valid_ways;
  logic [WW-1:0]          way_p, way_r, way_l;
  logic                   rdy_p, rdy_r, rdy_l;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] lfsr_m;

  multi_port_replace #(.DEPTH(DEPTH), .WAY_NUM(WN), .HIT_PORTS(HP), .MODE(0)) u_plru (
    .clk(clk), .rst(rst), .clear(clear), .hit_en(hit_en), .hit_way(hit_way),
    .hit_index(hit_index), .miss_en(miss_en), .miss_index(miss_index),
    .miss_valid_ways(miss_valid_ways), .miss_way(way_p), .miss_ready(rdy_p));

  multi_port_replace #(.DEPTH(DEPTH), .WAY_NUM(WN), .HIT_PORTS(HP), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .clear(clear), .hit_en(hit_en), .hit_way(hit_way),
    .hit_index(hit_index), .miss_en(miss_en), .miss_index(miss_index),
    .miss_valid_ways(miss_valid_ways), .miss_way(way_r), .miss_ready(rdy_r));

  multi_port_replace #(.DEPTH(DEPTH), .WAY_NUM(WN), .HIT_PORTS(HP), .MODE(2)) u_lfsr (
    .clk(clk), .rst(rst), .clear(clear), .hit_en(hit_en), .hit_way(hit_way),
    .hit_index(hit_index), .miss_en(miss_en), .miss_index(miss_index),
    .miss_valid_ways(miss_valid_ways), .miss_way(way_l), .miss_ready(rdy_l));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    assert (obs === 32'(exp)) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Issue one miss; a negative expectation skips that instance's way check.
  task automatic miss(input string tag, input int idx, input logic [3:0] vw,
                      input int e_plru, input int e_rr, input logic clr = 1'b0);
    int e_lf;
    logic [AW-1:0] ia;
    ia = AW'(idx);
    e_lf = int'(lfsr_m[1:0]);
    for (int i = WN - 1; i >= 0; i--) if (!vw[i]) e_lf = i;
    lfsr_m = clr ? 16'h0001 : lfsr_step(lfsr_m);
    miss_en = 1'b1;
    miss_index = ia;
    miss_valid_ways = vw;
    clear = clr;
    @(negedge clk);
    miss_en = 1'b0;
    clear = 1'b0;
    chk($sformatf("%s.rdy_plru", tag), 32'(rdy_p), 1);
    chk($sformatf("%s.rdy_rr", tag), 32'(rdy_r), 1);
    chk($sformatf("%s.rdy_lfsr", tag), 32'(rdy_l), 1);
    if (e_plru >= 0) chk($sformatf("%s.way_plru", tag), 32'(way_p), e_plru);
    if (e_rr >= 0) chk($sformatf("%s.way_rr", tag), 32'(way_r), e_rr);
    chk($sformatf("%s.way_lfsr", tag), 32'(way_l), e_lf);
  endtask

  task automatic hit2(input logic [1:0] en, input int w0, input int i0, input int w1, input int i1);
    hit_en = en;
    hit_way[0] = WW'(w0);
    hit_index[0] = AW'(i0);
    hit_way[1] = WW'(w1);
    hit_index[1] = AW'(i1);
    @(negedge clk);
    hit_en = '0;
  endtask

  initial begin
    rst = 1'b0;
    clear = 1'b0;
    hit_en = '0;
    hit_way = '0;
    hit_index = '0;
    miss_en = 1'b0;
    miss_index = '0;
    miss_valid_ways = '1;
    lfsr_m = 16'h0001;
    repeat (2) @(negedge clk);
    chk("reset.rdy_plru", 32'(rdy_p), 0);
    chk("reset.rdy_rr", 32'(rdy_r), 0);
    chk("reset.rdy_lfsr", 32'(rdy_l), 0);
    chk("reset.way_plru", 32'(way_p), 0);
    chk("reset.way_rr", 32'(way_r), 0);
    chk("reset.way_lfsr", 32'(way_l), 0);
    rst = 1'b1;
    @(negedge clk);

    miss("plru_seq0", 5, 4'b1111, 0, 0);
    miss("plru_seq1", 5, 4'b1111, 2, 1);
    miss("plru_seq2", 5, 4'b1111, 1, 2);
    miss("plru_seq3", 5, 4'b1111, 3, 3);
    @(negedge clk);
    chk("idle.rdy_plru", 32'(rdy_p), 0);
    chk("idle.hold_plru", 32'(way_p), 3);

    hit2(2'b01, 0, 3, 0, 0);
    miss("hit_then_miss", 3, 4'b1111, 2, 0);
    hit2(2'b11, 2, 7, 0, 7);
    miss("two_port_order", 7, 4'b1111, 3, 0);

    hit_en = 2'b01;
    hit_way[0] = 2'd0;
    hit_index[0] = 8'd11;
    miss("snapshot", 11, 4'b1111, 0, 0);
    hit_en = '0;
    miss("snapshot_after", 11, 4'b1111, 2, 1);

    miss("inv_1011", 20, 4'b1011, 2, 2);
    miss("inv_0000", 21, 4'b0000, 0, 0);
    miss("inv_follow", 21, 4'b1111, 2, 1);

    miss("rr0", 9, 4'b1111, -1, 0);
    miss("rr1", 9, 4'b1111, -1, 1);
    hit2(2'b11, 3, 9, 1, 9);
    miss("rr2", 9, 4'b1111, -1, 2);
    hit2(2'b01, 0, 9, 0, 0);
    miss("rr3", 9, 4'b1111, -1, 3);
    miss("rr4", 9, 4'b1111, -1, 0);
    @(negedge clk);
    chk("idle.rdy_rr", 32'(rdy_r), 0);
    chk("idle.hold_rr", 32'(way_r), 0);

    miss("clear_same_cycle", 9, 4'b1111, -1, 1, 1'b1);
    miss("after_clear_rr", 9, 4'b1111, 0, 0);
    clear = 1'b1;
    lfsr_m = 16'h0001;
    @(negedge clk);
    clear = 1'b0;
    miss("after_clear_plru", 5, 4'b1111, 0, 0);

    for (int k = 0; k < 1000; k++) miss("lfsr_run", 200, 4'b1111, -1, -1);

    miss_en = 1'b1;
    miss_index = 8'd5;
    miss_valid_ways = 4'b1111;
    @(posedge clk);
    #1;
    rst = 1'b0;
    miss_en = 1'b0;
    #1;
    chk("midreset.rdy_plru", 32'(rdy_p), 0);
    chk("midreset.rdy_rr", 32'(rdy_r), 0);
    chk("midreset.rdy_lfsr", 32'(rdy_l), 0);
    chk("midreset.way_plru", 32'(way_p), 0);
    @(negedge clk);
    rst = 1'b1;
    lfsr_m = 16'h0001;
    @(negedge clk);
    miss("post_reset", 5, 4'b1111, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_port_replace.md
# multi_port_replace

Parametrised cache-way replacement unit for the ICache, DCache and TLBs. It generalises the single-hit-port replacement contract to several hit ports per cycle and three selectable policies: tree-PLRU, round-robin and LFSR-random. It also adds invalid-way preference and a registered victim output with a valid flag. Per-set state lives in flops inside the block.

## Interface
- `DEPTH`, 256: number of sets; power of 2, ≥2.
- `WAY_NUM`, 4: associativity; power of 2, ≥2.
- `HIT_PORTS`, 2: number of independent hit-update ports, ≥1.
- `MODE`, 0: policy; 0 = tree-PLRU, 1 = round-robin, 2 = LFSR-random.
- Derived: `WAY_WIDTH` = $clog2(WAY_NUM), `ADDR_WIDTH` = $clog2(DEPTH).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous wipe of all policy state to reset values.
- `hit_en`  in  HIT_PORTS  per-port hit strobe.
- `hit_way`  in  HIT_PORTS×WAY_WIDTH  accessed way per port.
- `hit_index`  in  HIT_PORTS×ADDR_WIDTH  set per port.
- `miss_en`  in  1  victim request.
- `miss_index`  in  ADDR_WIDTH  set for the victim request.
- `miss_valid_ways`  in  WAY_NUM  line-valid bits of `miss_index`; bit=0 marks an invalid way.
- `miss_way`  out  WAY_WIDTH  registered victim way.
- `miss_ready`  out  1  `miss_way` is valid this cycle (one-cycle pulse).

## Operation
- Invalid preference (all modes): if `miss_valid_ways` has any 0 bit, the victim is the lowest-numbered invalid way. Otherwise the victim comes from the policy.
- PLRU state is WAY_NUM−1 bits per set, in heap order: node i has children 2i+1 (left, lower ways) and 2i+2.
  - Victim walk: from the root, bit 0 goes left and bit 1 goes right.
  - Touch of way w: every node on w's path is set to point away from w. A node whose left subtree contains w is set to 1; otherwise it is set to 0.
- PLRU touch sources: each enabled hit port touches its way. A miss touches its chosen victim, including an invalid-way pick.
- Round-robin state is a WAY_WIDTH counter per set.
  - The victim is the counter value.
  - Each miss increments that set's counter modulo WAY_NUM, whether or not an invalid way was picked.
  - Hits have no effect.
- LFSR mode uses one global 16-bit Fibonacci LFSR, taps 16,14,13,11, reset value 16'h0001.
  - The victim is LFSR[WAY_WIDTH−1:0].
  - The LFSR advances once per `miss_en`. Hits have no effect.
- Same-cycle ordering of state updates:
  - Hit ports apply in ascending port order, so the highest-numbered port is most recent.
  - The miss touch applies last.
  - Updates to different sets are independent.
- Victim snapshot: the victim for `miss_en` at cycle T is computed from state as it stood before any cycle-T update. Same-cycle hits to the same set do not influence that victim.
- `clear` overrides every hit and miss state update in its cycle, and all state returns to reset values. A `miss_en` in the same cycle still returns a victim computed from the pre-clear state.
- Out-of-range `hit_way` is impossible (width-exact). Hits to unused ports are ignored when `hit_en`=0.

## Timing
- Reset (async, `rst`=0):
  - All PLRU bits 0, all RR counters 0, LFSR 16'h0001.
  - `miss_way`=0, `miss_ready`=0.
  - Takes effect immediately, mid-request included; a pending victim is dropped.
- Victim latency: `miss_en` at edge T gives `miss_way` and `miss_ready`=1 during cycle T+1.
  - `miss_ready` deasserts in the next cycle unless another `miss_en` arrived.
  - `miss_way` holds its last value when `miss_ready`=0.
- Back-to-back misses to the same set are supported every cycle. The request at T+1 sees the state updated by the T miss.
- Hit updates are visible to a miss issued on the following cycle. There is no throughput stall and no backpressure.

## Test plan
- MODE=0, WAY_NUM=4, all ways valid; four consecutive misses to set 5 -> `miss_way` = 0, 2, 1, 3 on cycles T+1..T+4, `miss_ready`=1 each cycle.
- MODE=0: hit way 0 on set 3, then miss set 3 -> way 2; same-cycle hit port0 way 2 and port1 way 0 on set 7, then miss set 7 -> way 3.
- Any MODE: `miss_valid_ways`=4'b1011 -> way 2; 4'b0000 -> way 0; a following PLRU miss on that set with all valid -> way 2.
- MODE=1: five misses to set 9 -> 0,1,2,3,0; interleaved hits to set 9 change nothing; `clear` then miss -> 0.
- MODE=2, WAY_NUM=4: first miss after reset -> way 1 (LFSR 16'h0001); the sequence matches a reference LFSR model for 1000 misses.
- Assert `rst`=0 in the cycle after `miss_en` -> `miss_ready`=0 immediately; after release, a miss to set 5 in MODE=0 -> way 0.
